// File: rtl/dcim_pkg.sv
// Shared DCIM output-path constants and the activation saturation helper.
package dcim_pkg;

  localparam int ACC_WIDTH   = 51;
  localparam int BIAS_WIDTH  = 32;
  localparam int OUT_WIDTH   = 16;
  localparam int SHIFT_WIDTH = 6;
  localparam int RND_WIDTH   = ACC_WIDTH + 2;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] data;
  } act_t;

  function automatic act_t saturate(input logic signed [RND_WIDTH-1:0] val);
    act_t                        res;
    logic signed [RND_WIDTH-1:0] hi;
    logic signed [RND_WIDTH-1:0] lo;
    hi = {{(RND_WIDTH-OUT_WIDTH){OUT_MAX[OUT_WIDTH-1]}}, OUT_MAX};
    lo = {{(RND_WIDTH-OUT_WIDTH){OUT_MIN[OUT_WIDTH-1]}}, OUT_MIN};
    if (val > hi) begin
      res.sat  = 1'b1;
      res.data = OUT_MAX;
    end else if (val < lo) begin
      res.sat  = 1'b1;
      res.data = OUT_MIN;
    end else begin
      res.sat  = 1'b0;
      res.data = val[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcim_out_fifo.sv
// Synchronous FIFO holding {sat, data} activation entries; head is read combinationally.
module dcim_out_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dcim_requant_out.sv
// Requantises DCIM accumulator results (bias, rounding shift, saturate, ReLU)
// and buffers them in a small FIFO toward the activation SRAM writer.
module dcim_requant_out
  import dcim_pkg::*;
#(
  parameter int ACC_WIDTH  = dcim_pkg::ACC_WIDTH,
  parameter int BIAS_WIDTH = dcim_pkg::BIAS_WIDTH,
  parameter int OUT_WIDTH  = dcim_pkg::OUT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_done,
  input  logic signed [ACC_WIDTH-1:0]  nout,
  input  logic signed [BIAS_WIDTH-1:0] cfg_bias,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
  input  logic                         cfg_relu,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         ovf,
  input  logic                         ovf_clr,
  output logic [7:0]                   drop_cnt
);

  // Round-half-up arithmetic right shift; shift amounts beyond the accumulator clamp.
  function automatic logic signed [ACC_WIDTH+1:0] round_shift(
    input logic signed [ACC_WIDTH:0] sum,
    input logic [SHIFT_WIDTH-1:0]    shift
  );
    logic signed [ACC_WIDTH+1:0] ext;
    logic signed [ACC_WIDTH+1:0] half;
    int                          eff;
    eff = (int'(shift) > ACC_WIDTH) ? ACC_WIDTH : int'(shift);
    ext = {sum[ACC_WIDTH], sum};
    if (eff == 0) return ext;
    half = '0;
    half[eff-1] = 1'b1;
    return (ext + half) >>> eff;
  endfunction

  logic                         vld_p1, vld_p2, vld_p3;
  logic signed [ACC_WIDTH:0]    sum_p1;
  logic [SHIFT_WIDTH-1:0]       shift_p1;
  logic                         relu_p1, relu_p2;
  logic signed [ACC_WIDTH+1:0]  r_p2;
  act_t                         act_p2;
  logic signed [OUT_WIDTH-1:0]  data_p3;
  logic                         sat_p3;

  logic                         fifo_full, fifo_empty, push, pop, drop;
  logic [OUT_WIDTH:0]           head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= op_done;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // p0 -> p1: bias add at full width
  always_ff @(posedge clk) begin
    if (op_done) begin
      sum_p1   <= {nout[ACC_WIDTH-1], nout}
                + {{(ACC_WIDTH+1-BIAS_WIDTH){cfg_bias[BIAS_WIDTH-1]}}, cfg_bias};
      shift_p1 <= cfg_shift;
      relu_p1  <= cfg_relu;
    end
  end

  // p1 -> p2: rounding shift
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      r_p2    <= round_shift(sum_p1, shift_p1);
      relu_p2 <= relu_p1;
    end
  end

  // sat reports clipping before ReLU zeroes negatives
  always_comb begin
    act_p2 = saturate(r_p2);
    if (relu_p2 && act_p2.data[OUT_WIDTH-1]) act_p2.data = '0;
  end

  // p2 -> p3: saturated activation
  always_ff @(posedge clk) begin
    if (vld_p2) begin
      data_p3 <= act_p2.data;
      sat_p3  <= act_p2.sat;
    end
  end

  // p3 -> FIFO: a full FIFO still accepts when the head leaves on the same edge
  assign pop  = out_valid && out_ready;
  assign push = vld_p3 && (!fifo_full || pop);
  assign drop = vld_p3 && fifo_full && !pop;

  dcim_out_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({sat_p3, data_p3}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[OUT_WIDTH-1:0] : '0;
  assign out_sat   = out_valid ? head[OUT_WIDTH] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= ovf_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dcim_requant_out.sv
// Scoreboard bench for dcim_requant_out: stimulus pushes expected activations,
// a negedge monitor pops and compares on every output handshake.
module tb_dcim_requant_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_done;
  logic [50:0] nout;
  logic [31:0] cfg_bias;
  logic [5:0]  cfg_shift;
  logic        cfg_relu;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  dcim_requant_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_done   (op_done),
    .nout      (nout),
    .cfg_bias  (cfg_bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted head against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", {out_sat, out_data});
      end else begin
        check("out_entry", {47'd0, out_sat, out_data}, {47'd0, exp_q.pop_front()});
      end
    end
  end

  // Drives one op_done cycle; the pulse is sampled by the next rising edge.
  task automatic issue(input longint n, input longint b, input int sh, input bit relu,
                       input bit keep, input logic [15:0] ed, input bit es);
    op_done   = 1'b1;
    nout      = 51'(n);
    cfg_bias  = 32'(b);
    cfg_shift = 6'(sh);
    cfg_relu  = relu;
    if (keep) exp_q.push_back({es, ed});
    @(posedge clk); #1;
    op_done   = 1'b0;
    nout      = 51'({$urandom, $urandom});
    cfg_bias  = $urandom;
    cfg_shift = 6'($urandom);
    cfg_relu  = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, (exp_q.size() == 0 && !out_valid), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; op_done = 1'b0; nout = '0; cfg_bias = '0; cfg_shift = '0;
    cfg_relu = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: visible after E0+3
    issue(4095, 0, 0, 0, 1, 16'h0FFF, 0);
    check("lat_e0", out_valid, 0);
    @(posedge clk); #1; check("lat_e1", out_valid, 0);
    @(posedge clk); #1; check("lat_e2", out_valid, 0);
    @(posedge clk); #1; check("lat_e3_valid", out_valid, 1);
    check("lat_e3_data", out_data, 16'h0FFF);
    drain("drain_latency");

    // Back-to-back directed vectors
    issue(4095, 0, 4, 0, 1, 16'h0100, 0);
    issue(4095, -4095, 0, 0, 1, 16'h0000, 0);
    issue(-100, 0, 0, 0, 1, 16'hFF9C, 0);
    issue(-100, 0, 0, 1, 1, 16'h0000, 0);
    issue(longint'(1) << 40, 0, 0, 0, 1, 16'h7FFF, 1);
    issue(-(longint'(1) << 40), 0, 0, 0, 1, 16'h8000, 1);
    issue(longint'(1) << 40, 0, 0, 1, 1, 16'h7FFF, 1);
    issue(-(longint'(1) << 40), 0, 0, 1, 1, 16'h0000, 1);
    issue(32767, 0, 0, 0, 1, 16'h7FFF, 0);
    issue(32768, 0, 0, 0, 1, 16'h7FFF, 1);
    issue(-32768, 0, 0, 0, 1, 16'h8000, 0);
    issue(-32769, 0, 0, 0, 1, 16'h8000, 1);
    issue(5, 0, 1, 0, 1, 16'h0003, 0);
    issue(-5, 0, 1, 0, 1, 16'hFFFE, 0);
    issue(-3, 0, 1, 0, 1, 16'hFFFF, 0);
    issue((longint'(1) << 50) - 1, 32'h7FFF_FFFF, 63, 0, 1, 16'h0001, 0);
    drain("drain_vectors");

    // Overflow: six results into a four-entry FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) issue(i, 0, 0, 0, (i <= 4), 16'(i), 0);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_set", ovf, 1);
    check("drop_cnt_2", drop_cnt, 2);
    check("full_head_valid", out_valid, 1);
    check("full_head_data", out_data, 16'h0001);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pop_rate_empty", out_valid, 0);
    check("pop_rate_queue", exp_q.size(), 0);
    check("ovf_held", ovf, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    check("drop_cnt_clr", drop_cnt, 0);

    // Reset while a result is in flight
    issue(99, 0, 0, 0, 0, 16'h0000, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_discard_valid", seen, 0);
    check("rst_discard_ovf", ovf, 0);
    issue(7, 0, 0, 0, 1, 16'h0007, 0);
    @(posedge clk); #1; check("post_rst_e1", out_valid, 0);
    @(posedge clk); #1; check("post_rst_e2", out_valid, 0);
    @(posedge clk); #1; check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 16'h0007);
    drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcim_requant_out.md
Name: dcim_requant_out

Overview:
- Downstream stage of the DCIM top macro; consumes the 51-bit signed accumulator `nout`, sampled on each `op_done` pulse.
- Adds a per-layer bias, applies a rounding arithmetic right shift, saturates to a 16-bit activation and applies optional ReLU.
- Buffers results in a small FIFO drained through a valid/ready port toward the activation SRAM writer.

Parameters:
- ACC_WIDTH, 51, width of the signed accumulator from the macro
- BIAS_WIDTH, 32, width of the signed bias
- OUT_WIDTH, 16, width of the signed output activation
- FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- op_done  input  1  one-cycle pulse from the macro; nout valid in the same cycle
- nout  input  ACC_WIDTH  signed accumulator result
- cfg_bias  input  BIAS_WIDTH  signed bias, sampled with nout
- cfg_shift  input  6  right-shift amount, sampled with nout
- cfg_relu  input  1  ReLU enable, sampled with nout
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  OUT_WIDTH  signed activation at FIFO head
- out_sat  output  1  head entry was clipped by saturation
- ovf  output  1  sticky flag: a result was dropped because the FIFO was full
- ovf_clr  input  1  synchronous clear of ovf and drop_cnt
- drop_cnt  output  8  count of dropped results, saturates at 255

Behaviour:
- Reset (async, active-low):
  - All pipeline valid bits cleared; FIFO emptied.
  - out_valid=0, out_data=0, out_sat=0, ovf=0, drop_cnt=0.
  - Applies mid-operation: in-flight results are discarded.
- Pipeline, edge E0 samples op_done=1:
  - S1 (E0): sum = sext(nout) + sext(cfg_bias), width ACC_WIDTH+1, no wrap. Latches shift and relu.
  - S2 (E1): eff = min(shift, ACC_WIDTH).
    - eff=0: r = sum.
    - eff>0: r = (sum + 2^(eff-1)) >>> eff, computed at ACC_WIDTH+2 bits (round half up).
  - S3 (E2): saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat=1 if clipped. Then, if relu and the result is negative, value=0; sat keeps its pre-ReLU meaning.
  - FIFO write (E3): out_valid is high in the cycle after E3 if the FIFO was empty.
- Throughput: one op_done per cycle. The pipeline never stalls; back-pressure acts only at the FIFO write.
- FIFO handshake:
  - Pop on an edge where out_valid && out_ready.
  - out_data and out_sat stay stable while out_valid && !out_ready.
- Full with an S3 result arriving:
  - If a pop occurs on the same edge, the write is accepted.
  - Otherwise the result is dropped, ovf is set, and drop_cnt increments (holds at 255).
- Empty with simultaneous write and pop: not possible, since a pop requires out_valid. The new entry is visible the cycle after the write.
- ovf_clr:
  - Clears ovf and drop_cnt on the next edge.
  - If a drop occurs on the same edge: ovf=1, drop_cnt=1.
- Config may change every cycle; only the values sampled alongside op_done affect that result.
- op_done=0: nout and cfg are ignored.

Decomposition:
- Package dcim_pkg holds:
  - ACC_WIDTH, OUT_WIDTH, BIAS_WIDTH, SHIFT_WIDTH=6 constants
  - OUT_MAX and OUT_MIN constants
  - a saturate function shared with other DCIM output paths
- Sub-module dcim_out_fifo: synchronous FIFO with FIFO_DEPTH entries, each {sat, data}, and full/empty flags. The requant pipeline is the parent.

Test Plan:
- nout=4095, bias=0, shift=0, relu=0 -> out_data=0x0FFF, out_sat=0, out_valid rises the cycle after E0+3.
- nout=4095, bias=0, shift=4 -> (4095+8)>>>4 = 256 -> out_data=0x0100. Then nout=4095, bias=-4095, shift=0 -> out_data=0.
- nout=-100, shift=0: relu=0 -> out_data=0xFF9C; relu=1 -> out_data=0x0000, out_sat=0.
- nout=2^40 -> out_data=0x7FFF, out_sat=1. nout=-2^40 -> out_data=0x8000, out_sat=1. nout=2^40, relu=1 -> 0x7FFF, out_sat=1.
- out_ready=0, six back-to-back op_done with nout=1..6 -> four entries kept, ovf=1, drop_cnt=2. Then out_ready=1 pops 1,2,3,4 in order, one per cycle. Then ovf_clr -> ovf=0, drop_cnt=0.
- op_done pulse, then rst_n low two cycles later for one cycle -> out_valid never rises, FIFO empty, ovf=0. A following op_done with nout=7 -> out_data=7 with normal latency.
